// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants; the colour stages import the
// same visible-window values so they are defined once.
package vga_pkg;
    localparam int CNT_W       = 16;
    localparam int CLK_DIV     = 4;
    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 784;
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 515;
endpackage

// File: rtl/pixel_tick_div.sv
// Board-clock prescaler; Pixel_Tick marks the last clk of each pixel period.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic Pixel_Tick
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign Pixel_Tick = (cnt == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters and sync/blanking flags; flags are registered from the
// next counter values so they always match the counters on the outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = vga_pkg::CLK_DIV,
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_VIS_START = vga_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_VIS_START = vga_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_pkg::V_VIS_END
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] H_Counter_Value,
    output logic [CNT_W-1:0] V_Counter_Value,
    output logic             Hsync,
    output logic             Vsync,
    output logic             Video_On,
    output logic             Pixel_Tick,
    output logic             Frame_Start
);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SY   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SY   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_VS   = CNT_W'(H_VIS_START);
    localparam logic [CNT_W-1:0] H_VE   = CNT_W'(H_VIS_END);
    localparam logic [CNT_W-1:0] V_VS   = CNT_W'(V_VIS_START);
    localparam logic [CNT_W-1:0] V_VE   = CNT_W'(V_VIS_END);

    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             wrap;

    pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk        (clk),
        .reset      (reset),
        .Pixel_Tick (Pixel_Tick)
    );

    always_comb begin
        h_nxt = H_Counter_Value;
        v_nxt = V_Counter_Value;
        wrap  = 1'b0;
        if (Pixel_Tick) begin
            if (H_Counter_Value == H_LAST) begin
                h_nxt = '0;
                if (V_Counter_Value == V_LAST) begin
                    v_nxt = '0;
                    wrap  = 1'b1;
                end else begin
                    v_nxt = V_Counter_Value + 1'b1;
                end
            end else begin
                h_nxt = H_Counter_Value + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            H_Counter_Value <= '0;
            V_Counter_Value <= '0;
            Hsync           <= 1'b0;
            Vsync           <= 1'b0;
            Video_On        <= 1'b0;
            Frame_Start     <= 1'b0;
        end else begin
            H_Counter_Value <= h_nxt;
            V_Counter_Value <= v_nxt;
            Hsync           <= (h_nxt >= H_SY);
            Vsync           <= (v_nxt >= V_SY);
            Video_On        <= (h_nxt >= H_VS) && (h_nxt < H_VE) &&
                               (v_nxt >= V_VS) && (v_nxt < V_VE);
            Frame_Start     <= wrap;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for line-level behaviour and a
// shrunken instance so several whole frames fit in a short run.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] d_h, d_v, s_h, s_v;
    logic d_hs, d_vs, d_von, d_tick, d_fs;
    logic s_hs, s_vs, s_von, s_tick, s_fs;

    int n_chk = 0;
    int n_fail = 0;

    vga_timing_gen u_dflt (
        .clk(clk), .reset(reset),
        .H_Counter_Value(d_h), .V_Counter_Value(d_v),
        .Hsync(d_hs), .Vsync(d_vs), .Video_On(d_von),
        .Pixel_Tick(d_tick), .Frame_Start(d_fs)
    );

    // 40x12 raster, 2 clks per pixel: 960 clks per frame
    vga_timing_gen #(
        .CLK_DIV(2), .H_TOTAL(40), .H_SYNC(6), .H_VIS_START(10), .H_VIS_END(34),
        .V_TOTAL(12), .V_SYNC(2), .V_VIS_START(3), .V_VIS_END(9)
    ) u_small (
        .clk(clk), .reset(reset),
        .H_Counter_Value(s_h), .V_Counter_Value(s_v),
        .Hsync(s_hs), .Vsync(s_vs), .Video_On(s_von),
        .Pixel_Tick(s_tick), .Frame_Start(s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_d_h", d_h, 0);   chk("rst_d_v", d_v, 0);
        chk("rst_d_sync", {d_hs, d_vs, d_von, d_fs, d_tick}, 0);
        chk("rst_s_h", s_h, 0);   chk("rst_s_v", s_v, 0);
        chk("rst_s_sync", {s_hs, s_vs, s_von, s_fs, s_tick}, 0);
    endtask

    initial begin
        int last_tick, n_tick, hs_low, d_cnt_err, d_hs_err;
        int last_fs, n_fs, vs_low, s_cnt_err, s_vs_err, s_von_err, vrow_err;
        int first_von_k, found;
        logic [15:0] prev_dh, prev_dv, prev_sh, prev_sv;
        int ph, ps;

        last_tick = -1; n_tick = 0; hs_low = 0; d_cnt_err = 0; d_hs_err = 0;
        last_fs = -1; n_fs = 0; vs_low = 0; s_cnt_err = 0; s_vs_err = 0;
        s_von_err = 0; vrow_err = 0; first_von_k = -1;
        prev_dh = 0; prev_dv = 0; prev_sh = 0; prev_sv = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state();

        for (int k = 0; k < 3300; k++) begin
            if (k > 0) @(negedge clk);
            // default instance
            if (k <= 4) begin
                chk("tick_latency", d_tick, (k == 3) ? 1 : 0);
                chk("h_latency", d_h, (k == 4) ? 1 : 0);
            end
            ph = k / 4;
            if (d_h != 16'(ph % 800) || d_v != 16'((ph / 800) % 525)) d_cnt_err++;
            if (d_hs != (d_h >= 96)) d_hs_err++;
            if (d_v == 0 && !d_hs) hs_low++;
            if (d_tick) begin
                if (last_tick >= 0 && n_tick <= 100) chk("tick_period", k - last_tick, 4);
                last_tick = k;
                n_tick++;
            end
            if (prev_dh == 799 && d_h != 799) begin
                chk("h_wrap", d_h, 0);
                chk("v_inc", d_v, prev_dv + 1);
            end
            // small instance
            ps = k / 2;
            if (s_h != 16'(ps % 40) || s_v != 16'((ps / 40) % 12)) s_cnt_err++;
            if (s_vs != (s_v >= 2)) s_vs_err++;
            if (k >= 960 && k < 1920 && !s_vs) vs_low++;
            if (s_von != (s_h >= 10 && s_h < 34 && s_v >= 3 && s_v < 9)) s_von_err++;
            if ((s_v == 2 || s_v == 9) && s_von) vrow_err++;
            if (s_v == 3 && k < 960) begin
                if (s_h == 9)  chk("von_h9",  s_von, 0);
                if (s_h == 10) chk("von_h10", s_von, 1);
                if (s_h == 33) chk("von_h33", s_von, 1);
                if (s_h == 34) chk("von_h34", s_von, 0);
            end
            if (s_von && first_von_k < 0) begin
                first_von_k = k;
                chk("first_von_hv", {s_h, s_v}, {16'd10, 16'd3});
            end
            if (s_fs) begin
                chk("fs_hv", {s_h, s_v}, 0);
                chk("fs_prev_hv", {prev_sh, prev_sv}, {16'd39, 16'd11});
                if (last_fs >= 0) chk("fs_spacing", k - last_fs, 960);
                else chk("fs_first", k, 960);
                last_fs = k;
                n_fs++;
            end
            prev_dh = d_h; prev_dv = d_v; prev_sh = s_h; prev_sv = s_v;
        end

        chk("d_counter_model", d_cnt_err, 0);
        chk("hsync_model", d_hs_err, 0);
        chk("hsync_low_clks", hs_low, 384);
        chk("tick_count_ok", (n_tick >= 100) ? 1 : 0, 1);
        chk("s_counter_model", s_cnt_err, 0);
        chk("vsync_model", s_vs_err, 0);
        chk("vsync_low_clks", vs_low, 160);
        chk("video_on_model", s_von_err, 0);
        chk("video_on_blank_rows", vrow_err, 0);
        chk("frame_start_count", n_fs, 3);

        // mid-frame reset
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            if (s_h == 20 && s_v == 6) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_point_found", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_state();
        n_fs = 0; s_cnt_err = 0;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) @(negedge clk);
            if (s_fs || d_fs) n_fs++;
            ps = k / 2;
            if (s_h != 16'(ps % 40) || s_v != 16'((ps / 40) % 12)) s_cnt_err++;
        end
        chk("no_partial_frame_start", n_fs, 0);
        chk("restart_counter_model", s_cnt_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
